// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 max-pooling stage.
//
// Consumes a row-major feature-map stream, one pixel per i_valid cycle, and
// emits one pooled value per 2x2 window. Column/row position is tracked
// internally. The pair maxima of each even row are parked in a line buffer of
// IMG_W/2 entries and folded into the following odd row.
//
// Optional build macro: MAXPOOL_RELU_EN
//   defined   -> final pooled value is clamped at zero (fused ReLU)
//   undefined -> raw signed maximum is output
module maxpool2x2_stream #(
    parameter int unsigned DW    = 16,
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clear,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic          o_last,
    output logic          o_busy
);

    // Line-buffer index width; column counter is one bit wider so that
    // col[CW-1:1] is directly the line-buffer index.
    localparam int unsigned KW     = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;
    localparam int unsigned CW     = KW + 1;
    localparam int unsigned RW     = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int unsigned LBUF_N = IMG_W / 2;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    // Window quadrant, {row_odd, col_odd}.
    localparam logic [1:0] Q_TOP_L = 2'b00;
    localparam logic [1:0] Q_TOP_R = 2'b01;
    localparam logic [1:0] Q_BOT_L = 2'b10;
    localparam logic [1:0] Q_BOT_R = 2'b11;

    // Signed DW-bit maximum; ties return a, which equals b anyway.
    function automatic logic [DW-1:0] smax(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return ($signed(a) >= $signed(b)) ? a : b;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [DW-1:0] hold_q, hold_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic          busy_q, busy_d;

    logic [DW-1:0] lbuf_q [LBUF_N];

    // ------------------------------------------------------------------
    // Position decode
    // ------------------------------------------------------------------
    logic [KW-1:0] lbuf_idx;
    logic [1:0]    quad;
    logic          col_wrap;
    logic          row_wrap;
    logic          frame_end;

    assign lbuf_idx  = col_q[CW-1:1];
    assign quad      = {row_q[0], col_q[0]};
    assign col_wrap  = (col_q == COL_LAST);
    assign row_wrap  = (row_q == ROW_LAST);
    assign frame_end = col_wrap && row_wrap;

    // ------------------------------------------------------------------
    // Datapath compares
    // ------------------------------------------------------------------
    logic [DW-1:0] lbuf_rdata;
    logic [DW-1:0] pair_max;
    logic [DW-1:0] up_max;
    logic [DW-1:0] pool_val;
    logic          lbuf_we;

    assign lbuf_rdata = lbuf_q[lbuf_idx];
    assign pair_max   = smax(hold_q, i_data);
    assign up_max     = smax(lbuf_rdata, i_data);

`ifdef MAXPOOL_RELU_EN
    // Only the emitted value is clamped; hold/lbuf keep raw maxima.
    assign pool_val = smax(pair_max, '0);
`else
    assign pool_val = pair_max;
`endif

    // Column/row counters: advance on each accepted pixel, clear wins.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (i_clear) begin
            col_d = '0;
            row_d = '0;
        end else if (i_valid) begin
            if (col_wrap) begin
                col_d = '0;
                row_d = row_wrap ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Per-quadrant datapath step and output/busy flag generation.
    always_comb begin
        hold_d      = hold_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        busy_d      = busy_q;
        lbuf_we     = 1'b0;
        if (i_clear) begin
            hold_d     = '0;
            out_data_d = '0;
            busy_d     = 1'b0;
        end else if (i_valid) begin
            busy_d = 1'b1;
            unique case (quad)
                Q_TOP_L: hold_d = i_data;
                Q_TOP_R: lbuf_we = 1'b1;
                Q_BOT_L: hold_d = up_max;
                Q_BOT_R: begin
                    out_data_d  = pool_val;
                    out_valid_d = 1'b1;
                    out_last_d  = frame_end;
                    if (frame_end) begin
                        busy_d = 1'b0;
                    end
                end
                default: hold_d = hold_q;
            endcase
        end
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            hold_q      <= hold_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
        end
    end

    // Line buffer: no reset, every entry is written on the even row before
    // the odd row reads it.
    always_ff @(posedge i_clk) begin
        if (lbuf_we) begin
            lbuf_q[lbuf_idx] <= pair_max;
        end
    end

    assign o_valid = out_valid_q;
    assign o_data  = out_data_q;
    assign o_last  = out_last_q;
    assign o_busy  = busy_q;

endmodule

// File: doc/maxpool2x2_stream.md
Name: maxpool2x2_stream

Overview:
- Streaming 2x2, stride-2 max-pooling stage. Sits directly downstream of the convolution/accumulator output and consumes its row-major feature-map stream one pixel per valid cycle.
- Tracks column and row position itself.
- Keeps partial row maxima in an internal line buffer of IMG_W/2 entries.
- Emits one pooled value per 2x2 window, with valid and end-of-frame flags.

Parameters:
- DW, 16, signed data width; must equal the global `DW.
- IMG_W, 8, input feature-map width in pixels; even, >=2.
- IMG_H, 8, input feature-map height in pixels; even, >=2.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_clear  in  1  synchronous frame restart; resets counters and flags.
- i_valid  in  1  i_data carries a pixel this cycle.
- i_data  in  DW  signed input pixel, row-major.
- o_valid  out  1  o_data holds a new pooled value (1-cycle pulse).
- o_data  out  DW  signed pooled value.
- o_last  out  1  pulses with o_valid on the final pooled value of a frame.
- o_busy  out  1  high from first accepted pixel until o_last; low otherwise.

Behaviour:
- Reset (i_rst_n=0, async): col_cnt=0, row_cnt=0, hold=0, o_valid=0, o_data=0, o_last=0, o_busy=0. Line buffer is not reset (always written before read).
- i_clear=1 at a clock edge: same state as reset. i_clear has priority over a simultaneous i_valid; that sample is dropped.
- No backpressure: a pixel is accepted on every cycle with i_valid=1. Cycles with i_valid=0 change no state except o_valid/o_last, which return to 0.
- Counters: col_cnt 0..IMG_W-1, then wraps to 0 and row_cnt increments. row_cnt 0..IMG_H-1, then wraps to 0 (next frame starts without a clear).
- Datapath per accepted pixel, with k = col_cnt>>1:
  - even row, even col: hold <= i_data.
  - even row, odd col: lbuf[k] <= max(hold, i_data).
  - odd row, even col: hold <= max(lbuf[k], i_data).
  - odd row, odd col: o_data <= max(hold, i_data); o_valid <= 1 next cycle.
- All compares are signed two's complement, DW bits, no widening. Ties select either operand (same value).
- Latency: o_valid rises on the edge that accepts the bottom-right pixel of a window, i.e. visible 1 cycle after that pixel is presented. o_data holds its value until the next pooled output.
- o_last=1 together with o_valid when row_cnt=IMG_H-1 and col_cnt=IMG_W-1.
- o_busy rises on the first accepted pixel of a frame and falls on the edge that asserts o_last.
- Output count per frame: (IMG_W/2)*(IMG_H/2).
- Reset or clear mid-frame discards the partial frame; no output is generated for incomplete windows.

Optional Feature:
- Macro MAXPOOL_RELU_EN.
- Defined: the final stage computes max(0, max(hold, i_data)), so negative pooled results are output as 0 (fused ReLU). Intermediate hold and lbuf values are not clamped.
- Undefined: o_data is the raw signed maximum and may be negative.

Test Plan:
- IMG_W=4, IMG_H=4, frame 1..16 row-major, continuous valid -> 4 pulses with o_data=6, 8, 14, 16; o_last only with 16; each pulse 1 cycle after pixels 6, 8, 14, 16.
- All-negative frame -16..-1 -> outputs -11, -9, -3, -1 without MAXPOOL_RELU_EN; 0, 0, 0, 0 with it.
- Same 1..16 frame with i_valid low on alternate cycles -> identical outputs and ordering; o_valid never asserted on idle cycles.
- i_rst_n pulsed low after pixel 7, then a fresh 1..16 frame -> no output from the aborted frame; fresh frame gives 6, 8, 14, 16. o_data=0 while reset is held.
- i_clear=1 with i_valid=1 on pixel 5, then a full 16-pixel frame -> pixel 5 dropped, counters restart, outputs 6, 8, 14, 16.
- Two back-to-back frames, no clear; 2nd frame = 1st frame values + 100 -> 8 outputs, o_last on the 4th and 8th; 2nd-frame values 106, 108, 114, 116.
